// File: rtl/bcp_pkg.sv
// bcp_pkg: shared types and sizing for the BCP slot dispatch decoder
package bcp_pkg;
  localparam int BCP_N_SLOTS = 8;
  typedef enum logic {IDLE, REQ} dispatch_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_DUP, ERR_RANGE, ERR_TIMEOUT} dispatch_err_t;
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: binary index to one-hot, all-zero for indices at or beyond N_SLOTS
module onehot_decoder #(
  parameter int N_SLOTS = 8,
  parameter int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic [IDX_W-1:0]   i_idx,
  output logic [N_SLOTS-1:0] o_onehot
);
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_bit
    assign o_onehot[g] = (i_idx == IDX_W'(g));
  end
endmodule

// File: rtl/bcp_slot_dispatch_decoder.sv
// bcp_slot_dispatch_decoder: index-to-one-hot slot dispatch with claim tracking; SLOT_TIMEOUT_EN adds an ack timeout
module bcp_slot_dispatch_decoder
  import bcp_pkg::*;
#(
  parameter int N_SLOTS = BCP_N_SLOTS,
  parameter int IDX_W   = $clog2(N_SLOTS)
`ifdef SLOT_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [IDX_W-1:0]   i_in_idx,
  input  logic               i_clear_claims,
  output logic [N_SLOTS-1:0] o_slot_req,
  input  logic [N_SLOTS-1:0] i_slot_ack,
  output logic               o_done,
  output logic [IDX_W-1:0]   o_done_idx,
  output logic [N_SLOTS-1:0] o_claimed_mask,
  output logic               o_err,
  output logic [1:0]         o_err_code
);
  dispatch_state_t    r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [N_SLOTS-1:0] r_req;
  logic [N_SLOTS-1:0] r_claimed;
  logic               r_done;
  logic [IDX_W-1:0]   r_done_idx;
  logic               r_err;
  dispatch_err_t      r_err_code;
  logic [N_SLOTS-1:0] w_in_oh;
  logic [N_SLOTS-1:0] w_idx_oh;
  logic [N_SLOTS-1:0] w_claimed_base;
  logic               w_range;
  logic               w_dup;
  logic               w_ack;
`ifdef SLOT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait;
`endif

  onehot_decoder #(.N_SLOTS(N_SLOTS), .IDX_W(IDX_W)) u_in_dec (
    .i_idx    (i_in_idx),
    .o_onehot (w_in_oh)
  );

  onehot_decoder #(.N_SLOTS(N_SLOTS), .IDX_W(IDX_W)) u_req_dec (
    .i_idx    (r_idx),
    .o_onehot (w_idx_oh)
  );

  // clear_claims takes effect before the duplicate check and the new claim bit
  always_comb begin
    w_claimed_base = i_clear_claims ? '0 : r_claimed;
    w_range        = {1'b0, i_in_idx} >= (IDX_W + 1)'(N_SLOTS);
    w_dup          = |(w_in_oh & w_claimed_base);
    w_ack          = |(i_slot_ack & w_idx_oh);
  end

  assign o_in_ready     = (r_state == IDLE);
  assign o_slot_req     = r_req;
  assign o_done         = r_done;
  assign o_done_idx     = r_done_idx;
  assign o_claimed_mask = r_claimed;
  assign o_err          = r_err;
  assign o_err_code     = r_err_code;

  // dispatch FSM with registered request, claim mask and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_req      <= '0;
      r_claimed  <= '0;
      r_done     <= 1'b0;
      r_done_idx <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
`ifdef SLOT_TIMEOUT_EN
      r_wait     <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_claimed <= w_claimed_base;
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            if (w_range) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_RANGE;
            end else if (w_dup) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_DUP;
            end else begin
              r_idx     <= i_in_idx;
              r_req     <= w_in_oh;
              r_claimed <= w_claimed_base | w_in_oh;
              r_state   <= REQ;
`ifdef SLOT_TIMEOUT_EN
              r_wait    <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (w_ack) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_done     <= 1'b1;
            r_done_idx <= r_idx;
`ifdef SLOT_TIMEOUT_EN
          end else if (r_wait == CNT_W'(TIMEOUT - 1)) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_claimed  <= w_claimed_base & ~w_idx_oh;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end else begin
            r_wait     <= r_wait + 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcp_slot_dispatch_decoder.sv
// tb_bcp_slot_dispatch_decoder: directed self-checking bench for the slot dispatch decoder
module tb_bcp_slot_dispatch_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_idx = '0;
  logic       clear_claims = 1'b0;
  logic [7:0] slot_req;
  logic [7:0] slot_ack = '0;
  logic       done;
  logic [2:0] done_idx;
  logic [7:0] claimed_mask;
  logic       err;
  logic [1:0] err_code;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcp_slot_dispatch_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_idx       (in_idx),
    .i_clear_claims (clear_claims),
    .o_slot_req     (slot_req),
    .i_slot_ack     (slot_ack),
    .o_done         (done),
    .o_done_idx     (done_idx),
    .o_claimed_mask (claimed_mask),
    .o_err          (err),
    .o_err_code     (err_code)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (slot_req !== 8'h00) begin bad++; $display("FAIL reset_req got=%h exp=00", slot_req); end
    total++; if (claimed_mask !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h exp=00", claimed_mask); end
    total++; if ({done, err, err_code} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {done, err, err_code}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_idx = 3'd5;
    tick();
    in_valid = 1'b0;
    total++; if (slot_req !== 8'b0010_0000) begin bad++; $display("FAIL basic_req got=%h exp=20", slot_req); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (slot_req !== 8'h20 || done !== 1'b0) begin bad++; $display("FAIL basic_hold got=%h/%b exp=20/0", slot_req, done); end
    end
    slot_ack = 8'h20;
    tick();
    slot_ack = 8'h00;
    total++; if (done !== 1'b1 || done_idx !== 3'd5) begin bad++; $display("FAIL basic_done got=%b/%0d exp=1/5", done, done_idx); end
    total++; if (slot_req !== 8'h00 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_release got=%h/%b exp=00/1", slot_req, in_ready); end
    total++; if (claimed_mask !== 8'h20) begin bad++; $display("FAIL basic_mask got=%h exp=20", claimed_mask); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", done); end
  endtask

  task automatic test_duplicate();
    in_valid = 1'b1; in_idx = 3'd2;
    tick();
    in_valid = 1'b0; slot_ack = 8'h04;
    tick();
    slot_ack = 8'h00;
    total++; if (done !== 1'b1 || done_idx !== 3'd2) begin bad++; $display("FAIL dup_first_done got=%b/%0d exp=1/2", done, done_idx); end
    in_valid = 1'b1; in_idx = 3'd2;
    tick();
    in_valid = 1'b0;
    total++; if (err !== 1'b1 || err_code !== 2'b01) begin bad++; $display("FAIL dup_err got=%b/%b exp=1/01", err, err_code); end
    total++; if (slot_req !== 8'h00 || in_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL dup_idle got=%h/%b/%b exp=00/1/0", slot_req, in_ready, done); end
    total++; if (claimed_mask !== 8'h24) begin bad++; $display("FAIL dup_mask got=%h exp=24", claimed_mask); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL dup_pulse got=%b exp=0", err); end
  endtask

  task automatic test_foreign_ack();
    clear_claims = 1'b1;
    tick();
    clear_claims = 1'b0;
    total++; if (claimed_mask !== 8'h00) begin bad++; $display("FAIL clear_idle got=%h exp=00", claimed_mask); end
    in_valid = 1'b1; in_idx = 3'd2;
    tick();
    in_valid = 1'b0; slot_ack = 8'hFB;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (slot_req !== 8'h04 || done !== 1'b0) begin bad++; $display("FAIL foreign_hold got=%h/%b exp=04/0", slot_req, done); end
    end
    slot_ack = 8'h04;
    tick();
    slot_ack = 8'h00;
    total++; if (done !== 1'b1 || done_idx !== 3'd2 || slot_req !== 8'h00) begin bad++; $display("FAIL foreign_done got=%b/%0d/%h exp=1/2/00", done, done_idx, slot_req); end
  endtask

  task automatic test_clear_with_accept();
    in_valid = 1'b1; in_idx = 3'd5;
    tick();
    in_valid = 1'b0; slot_ack = 8'h20;
    tick();
    slot_ack = 8'h00;
    total++; if (claimed_mask !== 8'h24) begin bad++; $display("FAIL clracc_pre got=%h exp=24", claimed_mask); end
    in_valid = 1'b1; in_idx = 3'd2; clear_claims = 1'b1;
    tick();
    in_valid = 1'b0; clear_claims = 1'b0;
    total++; if (claimed_mask !== 8'h04) begin bad++; $display("FAIL clracc_mask got=%h exp=04", claimed_mask); end
    total++; if (slot_req !== 8'h04 || err !== 1'b0) begin bad++; $display("FAIL clracc_req got=%h/%b exp=04/0", slot_req, err); end
    clear_claims = 1'b1;
    tick();
    clear_claims = 1'b0;
    total++; if (claimed_mask !== 8'h00 || slot_req !== 8'h04) begin bad++; $display("FAIL clrreq got=%h/%h exp=00/04", claimed_mask, slot_req); end
    slot_ack = 8'h04;
    tick();
    slot_ack = 8'h00;
    total++; if (done !== 1'b1 || done_idx !== 3'd2) begin bad++; $display("FAIL clrreq_done got=%b/%0d exp=1/2", done, done_idx); end
  endtask

`ifdef SLOT_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    in_valid = 1'b1; in_idx = 3'd7;
    tick();
    in_valid = 1'b0;
    total++; if (claimed_mask[7] !== 1'b1) begin bad++; $display("FAIL to_claim got=%b exp=1", claimed_mask[7]); end
    while (slot_req === 8'h80 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n != 16) begin bad++; $display("FAIL to_cycles got=%0d exp=16", n); end
    total++; if (err !== 1'b1 || err_code !== 2'b11 || done !== 1'b0) begin bad++; $display("FAIL to_err got=%b/%b/%b exp=1/11/0", err, err_code, done); end
    total++; if (claimed_mask[7] !== 1'b0 || slot_req !== 8'h00) begin bad++; $display("FAIL to_release got=%b/%h exp=0/00", claimed_mask[7], slot_req); end
    tick();
  endtask
`else
  task automatic test_timeout();
    in_valid = 1'b1; in_idx = 3'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      total++; if (slot_req !== 8'h80 || err !== 1'b0) begin bad++; $display("FAIL notimeout_hold cyc=%0d got=%h/%b exp=80/0", i, slot_req, err); end
      tick();
    end
    slot_ack = 8'h80;
    tick();
    slot_ack = 8'h00;
    total++; if (done !== 1'b1 || done_idx !== 3'd7) begin bad++; $display("FAIL notimeout_done got=%b/%0d exp=1/7", done, done_idx); end
  endtask
`endif

  task automatic test_reset_mid();
    in_valid = 1'b1; in_idx = 3'd3;
    tick();
    in_valid = 1'b0;
    total++; if (slot_req !== 8'h08) begin bad++; $display("FAIL rstmid_pre got=%h exp=08", slot_req); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (slot_req !== 8'h00 || claimed_mask !== 8'h00) begin bad++; $display("FAIL rstmid_async got=%h/%h exp=00/00", slot_req, claimed_mask); end
    slot_ack = 8'h08;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_quiet got=%b/%b/%b exp=0/0/1", done, err, in_ready); end
    end
    slot_ack = 8'h00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duplicate();
    test_foreign_ack();
    test_clear_with_accept();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
